multich_interpolator: RTL and testbench
=======================================

MULTICH_INTERPOLATOR -- requirements
Module: multich_interpolator

Interface
- REQ-001 SHALL have parameter DATA_W, default 24: signed sample width per channel.
- REQ-002 SHALL have parameter NUM_CH, default 2: channel count, packed with channel 0 in the LSBs.
- REQ-003 SHALL have parameter FRAC_W, default 11: width of the input-period counter.
- REQ-004 SHALL have parameter OUT_DIV, default 512: clocks per output tick (49.152 MHz / 512 = 96 kHz).
- REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
- REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
- REQ-007 SHALL have port run, input, 1 bit: enable; low clears tick generation, counters and overrun.
- REQ-008 SHALL have port mode, input, 1 bit: 0 = zero-order hold, 1 = linear interpolation; sampled at tick.
- REQ-009 SHALL have port din_en, input, 1 bit: strobe marking a new input sample frame.
- REQ-010 SHALL have port din, input, NUM_CH*DATA_W bits: input samples, valid when din_en is high.
- REQ-011 SHALL have port dout_valid, output, 1 bit: one-cycle strobe marking a new output frame.
- REQ-012 SHALL have port dout, output, NUM_CH*DATA_W bits: output samples, registered and held between strobes.
- REQ-013 SHALL have port busy, output, 1 bit: high while the engine is not IDLE.
- REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a tick is dropped.

Function
- REQ-015 SHALL keep d0 (newest) and d1 (previous) per channel; on din_en, d1<=d0 and d0<=din.
- REQ-016 SHALL clear counter cnt to 0 on din_en and capture P<=cnt; otherwise cnt increments, saturating at 2^FRAC_W-1 with no wrap.
- REQ-017 SHALL count valid din_en strobes since run rose, saturating at 2.
- REQ-018 SHALL assert an internal tick for one cycle every OUT_DIV clocks while run=1; the first tick occurs OUT_DIV clocks after run rises.
- REQ-019 SHALL, on a tick in IDLE, snapshot mode, a=min(cnt,P), P, and all d0/d1 as registered in that cycle, ignoring a same-cycle din_en update.
- REQ-020 SHALL implement states IDLE -> LATCH -> (per channel: MULT -> DIV -> ADD) -> DONE -> IDLE, advancing the channel index in ADD.
- REQ-021 SHALL compute in MULT, in 1 cycle: prod = (d0-d1)*a, with diff DATA_W+1 signed and prod DATA_W+FRAC_W+2 signed.
- REQ-022 SHALL compute in DIV, in exactly QW=DATA_W+FRAC_W+1 cycles: q = prod/P by a restoring shift-subtract divider on magnitudes, sign applied after, truncating toward zero.
- REQ-023 SHALL compute in ADD, in 1 cycle: out_c = d1 + q[DATA_W-1:0]; since a<=P, no saturation is needed.
- REQ-024 SHALL bypass arithmetic when mode=0, P=0, or the valid count <2, using out_c=d0 (0 if there has been no din_en), while still spending the same cycles.
- REQ-025 SHALL, in DONE, update dout in one cycle from all channels and pulse dout_valid for exactly one cycle.
- REQ-026 SHALL have tick-to-dout_valid latency of exactly 2 + NUM_CH*(QW+2) cycles (78 at defaults).
- REQ-027 SHALL, on a tick while busy, drop the tick, set overrun, and leave the current computation unaffected.
- REQ-028 SHALL, when run falls mid-computation, complete the current frame; no new ticks occur.
- REQ-029 SHALL resolve simultaneous din_en and tick per REQ-019; din_en takes effect on the sample registers in that same cycle.

Reset
- REQ-030 SHALL, with reset_n low at a clock edge, return the state machine to IDLE and clear dout, dout_valid, busy, overrun, counters, P, the valid count and all d0/d1 to 0.
- REQ-031 SHALL, on reset mid-computation, abort the frame with no dout_valid pulse.
- REQ-032 SHALL require reset_n high for 1 cycle before the first tick counts.

Verification
- REQ-033 SHALL verify linear interpolation (defaults, din_en every 1024 clocks, d1=0, d0=1000, tick at cnt=256, P=1023): dout ch0 = 250, with dout_valid 78 cycles after the tick.
- REQ-034 SHALL verify negative rounding (d1=100, d0=-100, a=512, P=1023): prod=-102400, q=-100 (truncated toward zero), dout=0.
- REQ-035 SHALL verify hold mode (mode=0, same stimulus as REQ-033): dout=1000; verify startup with a single din_en then a tick: dout=d0.
- REQ-036 SHALL verify overrun (OUT_DIV=32, NUM_CH=2): the second tick is dropped, overrun=1, the first frame completes correctly, and run low clears overrun.
- REQ-037 SHALL verify reset abort (reset_n low for 1 cycle during DIV of ch1): busy=0, no dout_valid, dout=0 the next cycle.
- REQ-038 SHALL verify simultaneous din_en and tick: the output uses the pre-strobe d0/d1/cnt, and the next frame uses the new pair.

Source files
------------

// File: rtl/multich_interpolator.sv
// multich_interpolator: multi-channel zero-order-hold / linear rate converter.
// A single shared engine computes each channel in turn: multiply, divide, add.
module multich_interpolator #(
  parameter int DATA_W  = 24,
  parameter int NUM_CH  = 2,
  parameter int FRAC_W  = 11,
  parameter int OUT_DIV = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic                     mode,
  input  logic                     din_en,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     dout_valid,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     busy,
  output logic                     overrun
);

  localparam int QW  = DATA_W + FRAC_W + 1;
  localparam int PW  = DATA_W + FRAC_W + 2;
  localparam int BW  = NUM_CH * DATA_W;
  localparam int TW  = OUT_DIV > 1 ? $clog2(OUT_DIV) : 1;
  localparam int CW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int DCW = $clog2(QW);

  typedef enum logic [2:0] {
    IDLE, LATCH, MULT, DIV, ADD, DONE
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]     d0, d1, s_d0, s_d1, res;
  logic [FRAC_W-1:0] cnt, p, s_a, s_p, rem;
  logic [1:0]        vcnt;
  logic [TW-1:0]     tcnt;
  logic              tick, s_byp, neg, qbit;
  logic [CW-1:0]     ch;
  logic [DCW-1:0]    dcnt;
  logic [QW-1:0]     nq, pmag;
  logic [FRAC_W:0]   rsh;
  logic [DATA_W-1:0] c_d0, c_d1, qlo;
  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   prod;

  assign tick = run && (tcnt == TW'(OUT_DIV - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // input side: sample history, period measurement, valid count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d0   <= '0;
      d1   <= '0;
      cnt  <= '0;
      p    <= '0;
      vcnt <= '0;
    end else begin
      if (din_en) begin
        d1 <= d0;
        d0 <= din;
      end
      if (!run) begin
        cnt  <= '0;
        vcnt <= '0;
      end else if (din_en) begin
        cnt <= '0;
        p   <= cnt;
        if (vcnt != 2'd2) vcnt <= vcnt + 2'd1;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign c_d0 = s_d0[ch*DATA_W +: DATA_W];
  assign c_d1 = s_d1[ch*DATA_W +: DATA_W];
  assign diff = $signed({c_d0[DATA_W-1], c_d0})
              - $signed({c_d1[DATA_W-1], c_d1});
  assign prod = $signed({{(FRAC_W+1){diff[DATA_W]}}, diff})
              * $signed({{(DATA_W+1){1'b0}}, s_a});
  assign pmag = QW'(prod[PW-1] ? -prod : prod);

  // restoring divider: numerator bits shift out of nq, quotient bits in
  assign rsh  = {rem, nq[QW-1]};
  assign qbit = (rsh >= {1'b0, s_p});
  assign qlo  = DATA_W'(neg ? -nq : nq);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = LATCH;
      LATCH:   state_nx = MULT;
      MULT:    state_nx = DIV;
      DIV:     if (dcnt == DCW'(QW - 1)) state_nx = ADD;
      ADD:     state_nx = (ch == CW'(NUM_CH - 1)) ? DONE : MULT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_d0       <= '0;
      s_d1       <= '0;
      s_a        <= '0;
      s_p        <= '0;
      s_byp      <= 1'b0;
      ch         <= '0;
      dcnt       <= '0;
      nq         <= '0;
      rem        <= '0;
      neg        <= 1'b0;
      res        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (!run) begin
        overrun <= 1'b0;
      end else if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (tick) begin
            s_d0  <= d0;
            s_d1  <= d1;
            s_p   <= p;
            s_a   <= (cnt < p) ? cnt : p;
            s_byp <= !mode || (p == '0) || (vcnt != 2'd2);
            ch    <= '0;
          end
        end
        MULT: begin
          nq   <= pmag;
          neg  <= prod[PW-1];
          rem  <= '0;
          dcnt <= '0;
        end
        DIV: begin
          nq   <= {nq[QW-2:0], qbit};
          rem  <= qbit ? FRAC_W'(rsh - {1'b0, s_p})
                       : rsh[FRAC_W-1:0];
          dcnt <= dcnt + 1'b1;
        end
        ADD: begin
          res[ch*DATA_W +: DATA_W] <= s_byp ? c_d0 : c_d1 + qlo;
          ch <= ch + 1'b1;
        end
        DONE: begin
          dout       <= res;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multich_interpolator.sv
// tb_multich_interpolator: directed checks of interpolation, hold,
// startup, same-cycle strobe/tick, overrun and reset abort.
module tb_multich_interpolator;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run_a = 1'b0, mode_a = 1'b1, din_en_a = 1'b0;
  logic run_b = 1'b0, mode_b = 1'b1, din_en_b = 1'b0;
  logic [2*DW-1:0] din_a = '0, din_b = '0, dout_a, dout_b;
  logic dout_valid_a, busy_a, overrun_a;
  logic dout_valid_b, busy_b, overrun_b;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  multich_interpolator dut_a (
    .clk(clk), .reset_n(reset_n), .run(run_a), .mode(mode_a),
    .din_en(din_en_a), .din(din_a), .dout_valid(dout_valid_a),
    .dout(dout_a), .busy(busy_a), .overrun(overrun_a)
  );

  multich_interpolator #(.OUT_DIV(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run_b), .mode(mode_b),
    .din_en(din_en_b), .din(din_b), .dout_valid(dout_valid_b),
    .dout(dout_b), .busy(busy_b), .overrun(overrun_b)
  );

  function automatic int chv(input logic [2*DW-1:0] v, input int c);
    logic signed [DW-1:0] t;
    t = v[c*DW +: DW];
    return int'(t);
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic goto_e(input int e);
    while (ecnt < e) adv();
  endtask

  task automatic strobe(input bit b, input int e, input int c0, input int c1);
    goto_e(e - 1);
    if (b) begin
      din_en_b = 1'b1;
      din_b = {DW'(c1), DW'(c0)};
    end else begin
      din_en_a = 1'b1;
      din_a = {DW'(c1), DW'(c0)};
    end
    adv();
    din_en_a = 1'b0;
    din_en_b = 1'b0;
  endtask

  task automatic wait_valid(input bit b, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      adv();
      if ((b ? dout_valid_b : dout_valid_a) === 1'b1) begin
        at = ecnt;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) adv();
    checks++;
    if (dout_a !== '0) begin
      errors++; $display("FAIL rst_dout: got %h expected 0", dout_a);
    end
    checks++;
    if (dout_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got valid=%b busy=%b expected 0 0",
                         dout_valid_a, busy_a);
    end
    checks++;
    if (overrun_a !== 1'b0 || overrun_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL rst_ovr: got a=%b b=%b busy_b=%b expected 0",
                         overrun_a, overrun_b, busy_b);
    end
    reset_n = 1'b1;
    adv();
  endtask

  task automatic test_linear();
    int at;
    mode_a = 1'b1;
    run_a = 1'b1;
    ecnt = 0;
    strobe(0, 255, 0, -2000);
    strobe(0, 1279, 1000, 2000);
    goto_e(1536);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL lin_busy: got %b expected 1", busy_a);
    end
    wait_valid(0, at);
    checks++;
    if (at !== 1614) begin
      errors++; $display("FAIL lin_latency: got %0d expected 1614", at);
    end
    checks++;
    if (chv(dout_a, 0) !== 250) begin
      errors++; $display("FAIL lin_ch0: got %0d expected 250", chv(dout_a, 0));
    end
    checks++;
    if (chv(dout_a, 1) !== -1000) begin
      errors++; $display("FAIL lin_ch1: got %0d expected -1000", chv(dout_a, 1));
    end
    adv();
    checks++;
    if (dout_valid_a !== 1'b0 || chv(dout_a, 0) !== 250) begin
      errors++; $display("FAIL lin_pulse: got valid=%b ch0=%0d expected 0 250",
                         dout_valid_a, chv(dout_a, 0));
    end
  endtask

  task automatic test_negative();
    int at;
    strobe(0, 2559, 100, -5);
    strobe(0, 3583, -100, 7);
    goto_e(4096);
    wait_valid(0, at);
    checks++;
    if (at !== 4174) begin
      errors++; $display("FAIL neg_latency: got %0d expected 4174", at);
    end
    checks++;
    if (chv(dout_a, 0) !== 0) begin
      errors++; $display("FAIL neg_ch0: got %0d expected 0", chv(dout_a, 0));
    end
    checks++;
    if (chv(dout_a, 1) !== 1) begin
      errors++; $display("FAIL neg_ch1: got %0d expected 1", chv(dout_a, 1));
    end
  endtask

  task automatic test_hold();
    int at;
    mode_a = 1'b0;
    strobe(0, 4351, 0, -2000);
    strobe(0, 5375, 1000, 2000);
    goto_e(5632);
    wait_valid(0, at);
    checks++;
    if (at !== 5710 || chv(dout_a, 0) !== 1000 || chv(dout_a, 1) !== 2000) begin
      errors++; $display("FAIL hold: got at=%0d %0d/%0d expected 5710 1000/2000",
                         at, chv(dout_a, 0), chv(dout_a, 1));
    end
    run_a = 1'b0;
    mode_a = 1'b1;
    repeat (4) adv();
  endtask

  task automatic test_startup();
    int at;
    run_a = 1'b1;
    ecnt = 0;
    strobe(0, 100, 123, -456);
    goto_e(512);
    wait_valid(0, at);
    checks++;
    if (at !== 590 || chv(dout_a, 0) !== 123 || chv(dout_a, 1) !== -456) begin
      errors++; $display("FAIL startup: got at=%0d %0d/%0d expected 590 123/-456",
                         at, chv(dout_a, 0), chv(dout_a, 1));
    end
  endtask

  task automatic test_simultaneous();
    int at;
    strobe(0, 900, 923, 344);
    goto_e(1024);
    wait_valid(0, at);
    checks++;
    if (chv(dout_a, 0) !== 246 || chv(dout_a, 1) !== -333) begin
      errors++; $display("FAIL sim_pre1: got %0d/%0d expected 246/-333",
                         chv(dout_a, 0), chv(dout_a, 1));
    end
    strobe(0, 1536, -77, 1000);
    wait_valid(0, at);
    checks++;
    if (at !== 1614 || chv(dout_a, 0) !== 758 || chv(dout_a, 1) !== 179) begin
      errors++; $display("FAIL sim_same: got at=%0d %0d/%0d expected 1614 758/179",
                         at, chv(dout_a, 0), chv(dout_a, 1));
    end
    goto_e(2048);
    wait_valid(0, at);
    checks++;
    if (chv(dout_a, 0) !== 119 || chv(dout_a, 1) !== 871) begin
      errors++; $display("FAIL sim_next: got %0d/%0d expected 119/871",
                         chv(dout_a, 0), chv(dout_a, 1));
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    goto_e(2609);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL abort_busy_pre: got %b expected 1", busy_a);
    end
    reset_n = 1'b0;
    adv();
    reset_n = 1'b1;
    checks++;
    if (busy_a !== 1'b0 || dout_valid_a !== 1'b0 || dout_a !== '0) begin
      errors++; $display("FAIL abort_state: got busy=%b valid=%b dout=%h expected 0 0 0",
                         busy_a, dout_valid_a, dout_a);
    end
    for (int i = 0; i < 40; i++) begin
      adv();
      if (dout_valid_a === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_novalid: got %0d pulses expected 0", seen);
    end
    run_a = 1'b0;
    adv();
  endtask

  task automatic test_overrun();
    int at;
    run_b = 1'b1;
    mode_b = 1'b1;
    ecnt = 0;
    strobe(1, 2, 0, 100);
    strobe(1, 22, 1900, -90);
    goto_e(31);
    checks++;
    if (overrun_b !== 1'b0) begin
      errors++; $display("FAIL ovr_pre: got %b expected 0", overrun_b);
    end
    goto_e(70);
    checks++;
    if (overrun_b !== 1'b1 || busy_b !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got ovr=%b busy=%b expected 1 1",
                         overrun_b, busy_b);
    end
    wait_valid(1, at);
    checks++;
    if (at !== 110 || chv(dout_b, 0) !== 900 || chv(dout_b, 1) !== 10) begin
      errors++; $display("FAIL ovr_frame: got at=%0d %0d/%0d expected 110 900/10",
                         at, chv(dout_b, 0), chv(dout_b, 1));
    end
    checks++;
    if (overrun_b !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_b);
    end
    run_b = 1'b0;
    adv();
    checks++;
    if (overrun_b !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_b);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_negative();
    test_hold();
    test_startup();
    test_simultaneous();
    test_reset_abort();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
